// File: rtl/rd53_cmd_pkg.sv
// Shared constants and types for the RD53 command-stream transmitter:
// fixed frame words, trigger/data symbol tables and the frame-select enum.
package rd53_cmd_pkg;

    localparam logic [15:0] SYNC = 16'h817E;
    localparam logic [15:0] NOOP = 16'h6969;

    // Trigger-pattern symbols, indexed by the 4-bit BX pattern (entry 0 is never sent).
    localparam logic [7:0] TRIG_SYM [16] = '{
        8'h00, 8'h2B, 8'h2D, 8'h2E, 8'h33, 8'h35, 8'h36, 8'h39,
        8'h3A, 8'h3C, 8'h4B, 8'h4D, 8'h4E, 8'h53, 8'h55, 8'h56
    };

    // DC-balanced 8-bit data symbols, used here to carry the 5-bit trigger tag.
    localparam logic [7:0] DATA_SYM [32] = '{
        8'h6A, 8'h6C, 8'h71, 8'h72, 8'h74, 8'h8B, 8'h8D, 8'h8E,
        8'h93, 8'h95, 8'h96, 8'h99, 8'h9A, 8'h9C, 8'hA3, 8'hA5,
        8'hA6, 8'hA9, 8'h59, 8'hAC, 8'hB1, 8'hB2, 8'hB4, 8'hC3,
        8'hC5, 8'hC6, 8'hC9, 8'hCA, 8'hCC, 8'hD1, 8'hD2, 8'hD4
    };

    typedef enum logic [1:0] {FS_TRIG, FS_SYNC, FS_CMD, FS_NOOP} frame_sel_t;

endpackage

// File: rtl/rd53_cmd_tx_if.sv
// Command-frame handshake between the DAQ command source and the transmitter.
interface rd53_cmd_tx_if;
    logic [15:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;

    modport master (output cmd_data, output cmd_valid, input cmd_ready);
    modport slave  (input cmd_data, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/rd53_frame_serializer.sv
// 16-bit frame load/shift register with the free-running bit counter.
// Loads on bit_cnt==15 so the frame MSB appears on ser_out at bit_cnt==0.
module rd53_frame_serializer (
    input  logic        clk160,
    input  logic        rst_n,
    input  logic [15:0] frame_in,
    output logic        load,
    output logic [3:0]  bit_cnt,
    output logic        ser_out,
    output logic        frame_start,
    output logic        bx_strobe
);
    logic [3:0]  bit_cnt_reg;
    logic [15:0] shift_reg;

    // Bit counter starts at 15 so the first edge after reset loads a frame.
    always_ff @(posedge clk160 or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_reg <= 4'd15;
        end else begin
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
        end
    end

    // Parallel load at the frame boundary, otherwise shift MSB-first.
    always_ff @(posedge clk160 or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= 16'h0000;
        end else if (load) begin
            shift_reg <= frame_in;
        end else begin
            shift_reg <= {shift_reg[14:0], 1'b0};
        end
    end

    assign load        = (bit_cnt_reg == 4'd15);
    assign bit_cnt     = bit_cnt_reg;
    assign ser_out     = shift_reg[15];
    assign frame_start = (bit_cnt_reg == 4'd0);
    assign bx_strobe   = (bit_cnt_reg[1:0] == 2'd0);

endmodule

// File: rtl/rd53_cmd_tx.sv
// RD53 back-end command transmitter: captures per-BX triggers, holds one
// queued command frame and picks TRIG / SYNC / CMD / NOOP at every frame load.
// Optional periodic sync insertion is enabled by defining RD53_SYNC_INSERT_EN.
module rd53_cmd_tx
    import rd53_cmd_pkg::*;
#(
    parameter int SYNC_INTERVAL = 32
) (
    input  logic          clk160,
    input  logic          rst_n,
    input  logic          trig_in,
    output logic          bx_strobe,
    output logic          ser_out,
    output logic          frame_start,
    output logic [4:0]    trig_tag,
    rd53_cmd_tx_if.slave  cmd
);
    logic        load;
    logic [3:0]  bit_cnt;
    logic        trig_acc_reg [4];
    logic [3:0]  trig_pend;
    logic [4:0]  tag_reg;
    logic [4:0]  trig_tag_reg;
    logic        sync_due_reg;
    logic        hold_full_reg;
    logic [15:0] hold_reg;
    logic        alive_reg;
    logic        accept;
    frame_sel_t  sel_next;
    logic [15:0] frame_next;

    // Per-slot trigger capture; slot 0 (first BX of the frame) lands in bit 3.
    // The accumulator is consumed directly by the load so a trigger goes out in
    // the very next frame, and it clears at the load before slot 0 re-samples.
    for (genvar gi = 0; gi < 4; gi++) begin : g_trig_slot
        always_ff @(posedge clk160 or negedge rst_n) begin
            if (!rst_n) begin
                trig_acc_reg[gi] <= 1'b0;
            end else if (load) begin
                trig_acc_reg[gi] <= 1'b0;
            end else if (bit_cnt == 4'(4 * gi)) begin
                trig_acc_reg[gi] <= trig_in;
            end
        end
        assign trig_pend[3 - gi] = trig_acc_reg[gi];
    end

    // Strict priority frame selection.
    always_comb begin
        sel_next = FS_NOOP;
        if (trig_pend != 4'd0) begin
            sel_next = FS_TRIG;
        end else if (sync_due_reg) begin
            sel_next = FS_SYNC;
        end else if (hold_full_reg) begin
            sel_next = FS_CMD;
        end
    end

    // Frame word for the selected type.
    always_comb begin
        frame_next = NOOP;
        case (sel_next)
            FS_TRIG: frame_next = {TRIG_SYM[trig_pend], DATA_SYM[tag_reg]};
            FS_SYNC: frame_next = SYNC;
            FS_CMD:  frame_next = hold_reg;
            default: frame_next = NOOP;
        endcase
    end

    // Trigger tag advances only when a trigger frame is actually sent.
    always_ff @(posedge clk160 or negedge rst_n) begin
        if (!rst_n) begin
            tag_reg      <= 5'd0;
            trig_tag_reg <= 5'd0;
        end else if (load && sel_next == FS_TRIG) begin
            trig_tag_reg <= tag_reg;
            tag_reg      <= tag_reg + 5'd1;
        end
    end

    // One-entry holding register; an accept coinciding with a load waits for
    // the next load because selection only sees the registered full flag.
    always_ff @(posedge clk160 or negedge rst_n) begin
        if (!rst_n) begin
            hold_full_reg <= 1'b0;
            hold_reg      <= 16'h0000;
            alive_reg     <= 1'b0;
        end else begin
            alive_reg <= 1'b1;
            if (accept) begin
                hold_full_reg <= 1'b1;
                hold_reg      <= cmd.cmd_data;
            end else if (load && sel_next == FS_CMD) begin
                hold_full_reg <= 1'b0;
            end
        end
    end

`ifdef RD53_SYNC_INSERT_EN
    logic [7:0] frame_cnt_reg;

    // Sync becomes due after SYNC_INTERVAL-1 loads and stays due while preempted.
    always_ff @(posedge clk160 or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_reg <= 8'd0;
            sync_due_reg  <= 1'b1;
        end else if (load) begin
            if (sel_next == FS_SYNC) begin
                frame_cnt_reg <= 8'd0;
                sync_due_reg  <= 1'b0;
            end else if (!sync_due_reg) begin
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
                if ((frame_cnt_reg + 8'd1) == 8'(SYNC_INTERVAL - 1)) begin
                    sync_due_reg <= 1'b1;
                end
            end
        end
    end
`else
    // Only the first frame after reset is a sync.
    always_ff @(posedge clk160 or negedge rst_n) begin
        if (!rst_n) begin
            sync_due_reg <= 1'b1;
        end else if (load && sel_next == FS_SYNC) begin
            sync_due_reg <= 1'b0;
        end
    end
`endif

    assign cmd.cmd_ready = alive_reg & ~hold_full_reg;
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    assign trig_tag      = trig_tag_reg;

    rd53_frame_serializer u_ser (
        .clk160      (clk160),
        .rst_n       (rst_n),
        .frame_in    (frame_next),
        .load        (load),
        .bit_cnt     (bit_cnt),
        .ser_out     (ser_out),
        .frame_start (frame_start),
        .bx_strobe   (bx_strobe)
    );

endmodule

// File: doc/rd53_cmd_tx.md
# rd53_cmd_tx

Back-end command-stream transmitter for the RD53 emulation shell: the DAQ-side counterpart of the chip-side TTC receive path. It packs per-bunch-crossing trigger bits and queued 16-bit command frames into the RD53 serial command stream at 160 Mb/s, one bit per `clk160` cycle. Periodic sync frames and NOOP idles are inserted automatically. The serial output drives the LVDS TX buffer that feeds an emulated chip's `ttc_data_p/n` input.

## Interface
- `SYNC_INTERVAL`, default 32: frames between forced sync frames (valid range 2–255).
- `clk160`  in  1  — bit clock. One serial bit per cycle; BX = 4 cycles; frame = 16 cycles.
- `rst_n`  in  1  — reset, **asynchronous assert, active-low**.
- `trig_in`  in  1  — trigger request, sampled once per BX on the cycle `bx_strobe`=1.
- `bx_strobe`  out  1  — high on BX phase 0 (`bit_cnt[1:0]==0`).
- `cmd_data`  in  16  — pre-encoded command frame (ECR, BCR, WrReg, etc.).
- `cmd_valid`  in  1  — `cmd_data` valid.
- `cmd_ready`  out  1  — holding register empty; a frame is accepted when `cmd_valid & cmd_ready`.
- `ser_out`  out  1  — serial command bit, MSB of each frame first.
- `frame_start`  out  1  — high while `ser_out` carries bit 15 of a frame.
- `trig_tag`  out  5  — tag of the most recently sent trigger frame.

## Operation
- A 4-bit `bit_cnt` increments every cycle and wraps 15→0. The frame shift register loads when `bit_cnt==15`, and its MSB goes out next cycle.
- Trigger capture: `trig_in` is sampled at `bit_cnt` = 0, 4, 8 and 12 into `trig_acc[3:0]`, MSB first (the first BX of the frame goes to bit 3). At `bit_cnt==15` the accumulator moves to `trig_pend`. A new capture never collides with the previous one.
- Frame selection at each load, in strict priority order:
  1. `trig_pend != 0` → `{TRIG_SYM[trig_pend], DATA_SYM[tag]}`. `tag` then increments, wrapping 31→0, and `trig_tag` takes the sent tag.
  2. Sync due (see Configuration) → `SYNC` (0x817E).
  3. Holding register full → `cmd_hold`; the register is then emptied.
  4. Otherwise → `NOOP` (0x6969).
- A trigger preempts sync and command. A preempted sync stays due and goes out at the next non-trigger slot. A pending command waits.
- Command holding register: one entry.
  - `cmd_ready` = holding register empty and not in reset.
  - A frame accepted in the same cycle as a load is sent at the next load, not the current one.
- The first frame after reset release is always `SYNC`.

## Timing
- Reset values:
  - `ser_out`=0, `frame_start`=0, `bx_strobe`=0, `cmd_ready`=0, `trig_tag`=0.
  - `bit_cnt`=15, `tag`=0, sync due=1, holding register empty.
- Counters start on the first `clk160` edge after `rst_n` rises. `cmd_ready` goes to 1 on that edge.
- Trigger latency: a trigger in BX slot k of frame n appears in frame n+1. The first bit of frame n+1 is on `ser_out` 16 cycles after the slot-0 sample of frame n.
- Command latency: minimum 1 cycle from acceptance to load, plus the serialization time.
- Reset asserted mid-frame: all outputs clear immediately (asynchronous). The partial frame is discarded, and any held command and pending trigger are lost.

## Configuration
- `RD53_SYNC_INSERT_EN` defined:
  - A frame counter counts loads. When it reaches `SYNC_INTERVAL-1`, sync becomes due; the counter clears when SYNC is sent.
  - Back-to-back traffic cannot starve sync beyond trigger preemption.
- Not defined:
  - No periodic sync. SYNC is sent only as the first frame after reset.
  - Idle slots carry NOOP. Priority 2 is removed.

## Structure
- Package `rd53_cmd_pkg` holds:
  - `SYNC`=16'h817E and `NOOP`=16'h6969.
  - `TRIG_SYM[1..15]`, an 8-bit symbol table; pattern 4'b0001→8'h2B, 4'b1111→8'h56.
  - `DATA_SYM[0..31]`, an 8-bit DC-balanced symbol table; 0→8'h6A, 1→8'h6C.
  - Frame-select enum `{FS_TRIG, FS_SYNC, FS_CMD, FS_NOOP}`.
- One sub-module: `rd53_frame_serializer`. It contains the 16-bit load/shift register, `bit_cnt`, and the `frame_start` and `bx_strobe` generation. Frame selection, trigger capture and tag logic stay in `rd53_cmd_tx`.

## Test plan
- Reset release, no stimulus → first frame 0x817E, then 0x6969 repeating; with `RD53_SYNC_INSERT_EN`, 0x817E every 32nd frame.
- `trig_in`=1 in slot 3 only, tag=0 → next frame 0x2B6A; `trig_tag`=0; the following trigger frame uses tag 1 (0x??6C).
- `trig_in`=1 in all four slots for 33 consecutive frames → 0x56xx each frame, tags 0…31 then 0; no sync is sent until the first trigger-free frame, which is 0x817E.
- `cmd_data`=0x5A5A with `cmd_valid` held → accepted once, `cmd_ready` low until the load, 0x5A5A sent as a single frame. A trigger in the same frame delays it by exactly one frame.
- `rst_n` low at `bit_cnt`=7 with a command held → `ser_out`=0 immediately, the held command is dropped, and the first frame after release is 0x817E.
- `SYNC_INTERVAL`=2 with continuous commands → frames alternate SYNC, CMD (macro defined).
